// File: rtl/instr_mem_controller.sv
// rtl/instr_mem_controller.sv - round-robin arbiter from fetcher read ports onto single-ported program memory
module instr_mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_RESPOND  = 2'd2;

    logic [1:0]          state;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] grant_idx;
    logic [IDX_BITS-1:0] pick;
    logic                found;
    logic [IDX_BITS:0]   cand;

    // Scan starting at rr_ptr, wrapping modulo NUM_CONSUMERS; first valid wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_BITS+1)'(k);
            if (cand >= (IDX_BITS+1)'(NUM_CONSUMERS))
                cand = cand - (IDX_BITS+1)'(NUM_CONSUMERS);
            if (!found && consumer_read_valid[cand[IDX_BITS-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            rr_ptr              <= '0;
            grant_idx           <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_idx        <= pick;
                        mem_read_address <= consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
                        mem_read_valid   <= 1'b1;
                        rr_ptr           <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
                        state            <= S_WAIT_MEM;
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_read_ready) begin
                        mem_read_valid                                       <= 1'b0;
                        consumer_read_data[grant_idx*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        consumer_read_ready[grant_idx]                       <= 1'b1;
                        state                                                <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    consumer_read_ready <= '0;
                    state               <= S_IDLE;
                end
                default: begin
                    consumer_read_ready <= '0;
                    mem_read_valid      <= 1'b0;
                    state               <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_controller.sv
// tb/tb_instr_mem_controller.sv - scoreboard bench for instr_mem_controller
module tb_instr_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AW-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;

    always #5 clk = ~clk;

    instr_mem_controller #(
        .NUM_CONSUMERS(N),
        .ADDR_BITS    (AW),
        .DATA_BITS    (DW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data)
    );

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          sb[$];
    logic [DW-1:0] exp_data[N];
    int            total = 0;
    int            bad = 0;
    int            stall = 0;
    int            wait_cnt = 0;
    bit            mem_en = 1'b1;
    bit            auto_drop = 1'b1;
    logic          prev_mem_valid = 1'b0;
    logic          prev_mem_ready = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [N-1:0]  prev_ready = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 8'h1A) return 16'hBEEF;
        return {~a, a};
    endfunction

    function automatic logic [N*DW-1:0] packed_exp();
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_data[i];
        return v;
    endfunction

    task automatic expect_txn(input int i);
        logic [AW-1:0] a;
        a = consumer_read_address[i*AW +: AW];
        sb.push_back('{i, a, mem_fn(a)});
    endtask

    task automatic request(input int i, input logic [AW-1:0] a);
        consumer_read_address[i*AW +: AW] = a;
        expect_txn(i);
        consumer_read_valid[i] = 1'b1;
    endtask

    // One cycle: observe outputs at negedge, check against scoreboard, then drive memory model.
    task automatic step();
        txn_t e;
        @(negedge clk);
        if (reset) begin
            if (mem_read_valid && !prev_mem_valid) begin
                if (sb.size() == 0) chk("grant_with_empty_sb", 64'(mem_read_valid), 64'd0);
                else                chk("grant_addr", 64'(mem_read_address), 64'(sb[0].addr));
            end
            if (mem_read_valid && prev_mem_valid)
                chk("addr_stable", 64'(mem_read_address), 64'(prev_addr));
            if (consumer_read_ready != '0) begin
                if (sb.size() == 0) begin
                    chk("unexp_ready", 64'(consumer_read_ready), 64'd0);
                end else begin
                    e = sb.pop_front();
                    exp_data[e.idx] = e.data;
                    chk("ready_vec", 64'(consumer_read_ready), 64'(1) << e.idx);
                    chk("data_vec", 64'(consumer_read_data), 64'(packed_exp()));
                    chk("ready_lat", 64'(prev_mem_ready), 64'd1);
                    chk("pulse_w", 64'(prev_ready), 64'd0);
                    if (auto_drop) consumer_read_valid[e.idx] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) exp_data[i] = '0;
        end

        if (!reset) begin
            mem_read_ready = 1'b0;
            wait_cnt       = 0;
        end else if (mem_en) begin
            if (mem_read_ready) begin
                mem_read_ready = 1'b0;
                wait_cnt       = 0;
            end else if (mem_read_valid) begin
                if (wait_cnt >= stall) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_fn(mem_read_address);
                end else begin
                    wait_cnt++;
                end
            end
        end

        prev_mem_valid = mem_read_valid;
        prev_addr      = mem_read_address;
        prev_ready     = consumer_read_ready;
        prev_mem_ready = mem_read_ready;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb.size() > 0; c++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        consumer_read_valid = '0;
        repeat (2) step();
    endtask

    initial begin
        reset                 = 1'b0;
        consumer_read_valid   = '1;
        consumer_read_address = {8'h43, 8'h32, 8'h21, 8'h10};
        mem_read_ready        = 1'b0;
        mem_read_data         = '0;
        for (int i = 0; i < N; i++) exp_data[i] = '0;

        // reset held with requests pending
        repeat (3) step();
        chk("rst_ready", 64'(consumer_read_ready), 64'd0);
        chk("rst_data", 64'(consumer_read_data), 64'd0);
        chk("rst_mvalid", 64'(mem_read_valid), 64'd0);
        chk("rst_maddr", 64'(mem_read_address), 64'd0);
        for (int i = 0; i < N; i++) expect_txn(i);
        reset = 1'b1;
        drain(100);

        // single request, zero memory stall
        stall = 0;
        request(2, 8'h1A);
        step();
        chk("lat_mvalid", 64'(mem_read_valid), 64'd1);
        chk("lat_maddr", 64'(mem_read_address), 64'h1A);
        step();
        chk("lat_ready", 64'(consumer_read_ready), 64'b0100);
        repeat (3) step();
        chk("hold_data2", 64'(consumer_read_data[2*DW +: DW]), 64'hBEEF);
        chk("hold_ready", 64'(consumer_read_ready), 64'd0);
        drain(10);

        // round-robin from a fresh reset with every fetcher continuously valid
        reset = 1'b0;
        step();
        reset = 1'b1;
        stall = 1;
        auto_drop = 1'b0;
        consumer_read_address = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        consumer_read_valid = '1;
        for (int i = 0; i < N; i++) expect_txn(i);
        expect_txn(0);
        drain(200);
        auto_drop = 1'b1;

        // memory stall of 5 cycles
        stall = 5;
        request(1, 8'h77);
        drain(50);

        // collision: consumer 1 arrives while consumer 3 waits on memory
        stall = 3;
        request(3, 8'h3C);
        repeat (2) step();
        chk("coll_busy", 64'(mem_read_valid), 64'd1);
        request(1, 8'h91);
        drain(60);
        chk("coll_slice3", 64'(consumer_read_data[3*DW +: DW]), 64'(mem_fn(8'h3C)));
        chk("coll_slice1", 64'(consumer_read_data[1*DW +: DW]), 64'(mem_fn(8'h91)));

        // reset while waiting on memory; late memory response must be dropped
        stall = 20;
        request(0, 8'h05);
        repeat (3) step();
        chk("mid_busy", 64'(mem_read_valid), 64'd1);
        reset = 1'b0;
        mem_en = 1'b0;
        sb.delete();
        consumer_read_valid = '0;
        repeat (2) step();
        reset = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        step();
        mem_read_ready = 1'b0;
        repeat (4) step();
        chk("mid_ready", 64'(consumer_read_ready), 64'd0);
        chk("mid_data", 64'(consumer_read_data), 64'd0);
        chk("mid_mvalid", 64'(mem_read_valid), 64'd0);
        chk("mid_maddr", 64'(mem_read_address), 64'd0);
        mem_en = 1'b1;
        stall = 0;
        request(2, 8'h66);
        step();
        chk("post_rst_mvalid", 64'(mem_read_valid), 64'd1);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
